// File: rtl/alu_pkg.sv
// Shared types for the shared-ALU arbiter: op codes, FSM states.
// Imported by the ALU, the picker-based arbiter top and its bench.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SRL    = 4'd3,
        ALU_SRA    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_XOR    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    localparam logic [ALU_OP_W-1:0] ALU_OP_MAX = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic logic op_illegal(input logic [ALU_OP_W-1:0] op);
        return op > ALU_OP_MAX;
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU; unassigned op codes produce zero.
// Shift amount is taken from B[4:0].
module alu
    import alu_pkg::*;
(
    input  logic [ALU_OP_W-1:0] i_op,
    input  logic [31:0]         i_a,
    input  logic [31:0]         i_b,
    output logic [31:0]         o_y
);

    logic [31:0] w_y;

    always_comb begin
        w_y = '0;
        unique case (i_op)
            ALU_ADD:    w_y = i_a + i_b;
            ALU_SUB:    w_y = i_a - i_b;
            ALU_SLL:    w_y = i_a << i_b[4:0];
            ALU_SRL:    w_y = i_a >> i_b[4:0];
            ALU_SRA:    w_y = $unsigned($signed(i_a) >>> i_b[4:0]);
            ALU_SLT:    w_y = {31'b0, $signed(i_a) < $signed(i_b)};
            ALU_SLTU:   w_y = {31'b0, i_a < i_b};
            ALU_XOR:    w_y = i_a ^ i_b;
            ALU_OR:     w_y = i_a | i_b;
            ALU_AND:    w_y = i_a & i_b;
            ALU_PASS_B: w_y = i_b;
            default:    w_y = '0;
        endcase
    end

    assign o_y = w_y;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping around; reports one-hot grant, its index and any.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    localparam int IW = $clog2(N);

    always_comb begin
        int w_j;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            w_j = (int'(i_ptr) + k) % N;
            if (i_req[w_j]) begin
                o_gnt      = '0;
                o_gnt[w_j] = 1'b1;
                o_idx      = IW'(w_j);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU between N_REQ requesters,
// one transaction in flight: IDLE (accept) -> EXEC -> RESP (hold).
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_REQ-1:0]                 req_valid,
    output logic [N_REQ-1:0]                 req_ready,
    input  logic [N_REQ-1:0][ALU_OP_W-1:0]   req_op,
    input  logic [N_REQ-1:0][DATA_W-1:0]     req_a,
    input  logic [N_REQ-1:0][DATA_W-1:0]     req_b,
    output logic [N_REQ-1:0]                 rsp_valid,
    input  logic [N_REQ-1:0]                 rsp_ready,
    output logic [DATA_W-1:0]                rsp_data,
    output logic                             rsp_err,
    output logic                             busy
);

    localparam int IW = $clog2(N_REQ);

    if (DATA_W != 32 || N_REQ < 2 || N_REQ > 4) begin : g_bad_param
        $error("alu_share_arb: N_REQ must be 2..4 and DATA_W 32");
    end

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       r_gid;
    logic [ALU_OP_W-1:0] r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;

    logic [N_REQ-1:0]    w_pick_gnt;
    logic [IW-1:0]       w_pick_idx;
    logic                w_pick_any;
    logic [DATA_W-1:0]   w_alu_y;
    logic [N_REQ-1:0]    w_req_ready;
    logic                w_accept;
    logic                w_rsp_done;
    logic [IW-1:0]       w_ptr_nxt;

    rr_pick #(
        .N(N_REQ)
    ) u_pick (
        .i_req(req_valid),
        .i_ptr(r_rr_ptr),
        .o_gnt(w_pick_gnt),
        .o_idx(w_pick_idx),
        .o_any(w_pick_any)
    );

    // The ALU only ever sees the latched operands, never live inputs.
    alu u_alu (
        .i_op(r_op),
        .i_a (r_a),
        .i_b (r_b),
        .o_y (w_alu_y)
    );

    always_comb begin
        w_req_ready = '0;
        w_accept    = 1'b0;
        w_rsp_done  = 1'b0;
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                w_req_ready = w_pick_gnt;
                w_accept    = w_pick_any;
                if (w_pick_any) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                w_rsp_done = rsp_ready[r_gid];
                if (w_rsp_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_ptr_nxt = (r_gid == IW'(N_REQ - 1)) ? '0 : r_gid + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_gid      <= '0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op  <= req_op[w_pick_idx];
                r_a   <= req_a[w_pick_idx];
                r_b   <= req_b[w_pick_idx];
                r_gid <= w_pick_idx;
            end
            if (r_state == EXEC) begin
                r_rsp_data <= w_alu_y;
                r_rsp_err  <= op_illegal(r_op);
            end
            // Fairness pointer moves on completion only, not on accept.
            if (w_rsp_done) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (r_state == RESP) begin
            rsp_valid[r_gid] = 1'b1;
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != IDLE);

endmodule
